// File: rtl/lt24_pixel_writer.sv
// LT24 pixel writer: accepts pixels over a ready/valid handshake and issues
// 8080-style 16-bit bus writes (column set, page set, RAM write, data) to the
// ILI9341. Optional feature macro LT24_PIXEL_WRITER_SKIP_ADDR_EN tracks the
// panel's auto-increment pointer and skips the address writes for pixels
// arriving in raster order.
module lt24_pixel_writer #(
    parameter int unsigned LCD_WIDTH      = 240,
    parameter int unsigned LCD_HEIGHT     = 320,
    parameter int unsigned WR_LOW_CYCLES  = 1,
    parameter int unsigned WR_HIGH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        initDone,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic [15:0] LT24Data
);

    localparam int unsigned PERIOD  = WR_LOW_CYCLES + WR_HIGH_CYCLES;
    localparam int unsigned PH_W    = $clog2(PERIOD + 1);
    localparam logic [15:0] COL_END = 16'(LCD_WIDTH - 1);
    localparam logic [15:0] ROW_END = 16'(LCD_HEIGHT - 1);
    localparam logic [3:0]  LAST_IDX = 4'd10;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrop} state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [7:0]      px_q;
    logic [8:0]      py_q;
    logic [15:0]     pd_q;
    logic            transfer;
    logic            in_range;
    logic            hit;
    logic            write_last;
    logic [15:0]     x16;
    logic [15:0]     y16;

    assign write_last = (32'(ph_q) == PERIOD - 1);
    assign transfer   = pixelWrite && pixelReady;
    assign in_range   = (32'(xAddr) < LCD_WIDTH) && (32'(yAddr) < LCD_HEIGHT);
    assign x16        = {8'h00, px_q};
    assign y16        = {7'h00, py_q};
    assign LT24Rd_n   = 1'b1;

`ifdef LT24_PIXEL_WRITER_SKIP_ADDR_EN
    logic       pred_valid_q;
    logic [7:0] nx;
    logic [8:0] ny;
    logic       pred_ok;

    // Address the panel pointer will hold after the last latched pixel is written
    always_comb begin
        nx = px_q + 8'd1;
        ny = py_q;
        if (32'(px_q) == LCD_WIDTH - 1) begin
            nx = 8'd0;
            ny = (32'(py_q) == LCD_HEIGHT - 1) ? 9'd0 : py_q + 9'd1;
        end
    end

    // A transfer taken in the last DATA cycle follows a write that is completing now
    assign pred_ok = pred_valid_q || (state_q == StData);
    assign hit     = pred_ok && (xAddr == nx) && (yAddr == ny);

    // Prediction valid after a completed data write; dropped pixels invalidate it
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
        end else if (state_q == StDrop) begin
            pred_valid_q <= 1'b0;
        end else if (state_q == StData && write_last) begin
            pred_valid_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // State, sequencing counters and latched pixel
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ph_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            if (transfer) begin
                px_q <= xAddr;
                py_q <= yAddr;
                pd_q <= pixelData;
            end
        end
    end

    // Next state: walk the write phases, then the address writes, then data
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    idx_d   = '0;
                    ph_d    = '0;
                    state_d = !in_range ? StDrop : (hit ? StData : StAddr);
                end
            end
            StAddr: begin
                if (write_last) begin
                    ph_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = StData;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            StData: begin
                if (write_last) begin
                    ph_d  = '0;
                    idx_d = '0;
                    if (transfer) begin
                        state_d = !in_range ? StDrop : (hit ? StData : StAddr);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            StDrop: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus outputs: data/RS held for a whole write, strobe low for the first phase
    always_comb begin
        pixelReady = 1'b0;
        LT24Wr_n   = 1'b1;
        LT24CS_n   = 1'b1;
        LT24RS     = 1'b1;
        LT24Data   = 16'h0000;
        unique case (state_q)
            StIdle: begin
                pixelReady = initDone && !reset;
            end
            StAddr: begin
                LT24CS_n = 1'b0;
                LT24Wr_n = !(32'(ph_q) < WR_LOW_CYCLES);
                unique case (idx_q)
                    4'd0:    begin LT24RS = 1'b0; LT24Data = 16'h002A; end
                    4'd1:    LT24Data = {8'h00, x16[15:8]};
                    4'd2:    LT24Data = {8'h00, x16[7:0]};
                    4'd3:    LT24Data = {8'h00, COL_END[15:8]};
                    4'd4:    LT24Data = {8'h00, COL_END[7:0]};
                    4'd5:    begin LT24RS = 1'b0; LT24Data = 16'h002B; end
                    4'd6:    LT24Data = {8'h00, y16[15:8]};
                    4'd7:    LT24Data = {8'h00, y16[7:0]};
                    4'd8:    LT24Data = {8'h00, ROW_END[15:8]};
                    4'd9:    LT24Data = {8'h00, ROW_END[7:0]};
                    4'd10:   begin LT24RS = 1'b0; LT24Data = 16'h002C; end
                    default: LT24Data = 16'h0000;
                endcase
            end
            StData: begin
                LT24CS_n   = 1'b0;
                LT24Wr_n   = !(32'(ph_q) < WR_LOW_CYCLES);
                LT24Data   = pd_q;
                pixelReady = write_last && initDone && !reset;
            end
            StDrop: begin
                pixelReady = 1'b0;
            end
            default: begin
                pixelReady = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// Directed bench for lt24_pixel_writer (default 240x320, 1/1 strobe timing).
module tb_lt24_pixel_writer;

`ifdef LT24_PIXEL_WRITER_SKIP_ADDR_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int MISS_LOW = 23;
    localparam int HIT_LOW  = SKIP ? 1 : 23;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        initDone = 1'b0;
    logic [7:0]  xAddr = '0;
    logic [8:0]  yAddr = '0;
    logic [15:0] pixelData = '0;
    logic        pixelWrite = 1'b0;
    logic        pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
    logic [15:0] LT24Data;

    int checks = 0;
    int errors = 0;

    logic [16:0] wq[$];
    logic [16:0] exp_q[$];
    logic        prev_wr = 1'b1;

    lt24_pixel_writer dut (
        .clock      (clock),
        .reset      (reset),
        .initDone   (initDone),
        .xAddr      (xAddr),
        .yAddr      (yAddr),
        .pixelData  (pixelData),
        .pixelWrite (pixelWrite),
        .pixelReady (pixelReady),
        .LT24Wr_n   (LT24Wr_n),
        .LT24Rd_n   (LT24Rd_n),
        .LT24CS_n   (LT24CS_n),
        .LT24RS     (LT24RS),
        .LT24Data   (LT24Data)
    );

    always #5 clock = ~clock;

    // Record {RS, data} at the start of every strobe low phase
    always @(negedge clock) begin
        if (LT24Wr_n === 1'b0 && prev_wr === 1'b1) wq.push_back({LT24RS, LT24Data});
        prev_wr = LT24Wr_n;
    end

    task automatic build_full(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
        exp_q.push_back({1'b0, 16'h002A});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 8'h00, x});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 16'h00EF});
        exp_q.push_back({1'b0, 16'h002B});
        exp_q.push_back({1'b1, 15'h0000, y[8]});
        exp_q.push_back({1'b1, 8'h00, y[7:0]});
        exp_q.push_back({1'b1, 16'h0001});
        exp_q.push_back({1'b1, 16'h003F});
        exp_q.push_back({1'b0, 16'h002C});
        exp_q.push_back({1'b1, d});
    endtask

    task automatic build_pred(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
        if (SKIP) exp_q.push_back({1'b1, d});
        else build_full(x, y, d);
    endtask

    // Transfer one pixel, return how many cycles pixelReady stayed low afterwards
    task automatic send(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                        output int low);
        int n = 0;
        while (pixelReady !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (pixelReady !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: pixelReady=%b want 1 (timeout)", pixelReady);
        end
        xAddr = x; yAddr = y; pixelData = d; pixelWrite = 1'b1;
        @(posedge clock);
        #1 pixelWrite = 1'b0;
        low = 0;
        @(negedge clock);
        while (pixelReady !== 1'b1 && low < 200) begin
            low++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        initDone = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Data} !== {5'b01111, 16'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b wr=%b rd=%b cs=%b rs=%b data=%h want 0 1 1 1 1 0000",
                     pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Data);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (pixelReady !== 1'b1 || LT24CS_n !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got rdy=%b cs=%b want 1 1", pixelReady, LT24CS_n);
        end
    endtask

    task automatic test_first_miss();
        int low;
        wq = {}; exp_q = {};
        build_full(8'd0, 9'd0, 16'hF800);
        send(8'd0, 9'd0, 16'hF800, low);
        checks++;
        if (low != MISS_LOW) begin
            errors++; $display("FAIL first_miss_low: got %0d want %0d", low, MISS_LOW);
        end
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++; $display("FAIL first_miss_count: got %0d want %0d", wq.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL first_miss_w%0d: got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_hit();
        int low;
        wq = {}; exp_q = {};
        build_pred(8'd1, 9'd0, 16'h07E0);
        send(8'd1, 9'd0, 16'h07E0, low);
        checks++;
        if (low != HIT_LOW) begin
            errors++; $display("FAIL hit_low: got %0d want %0d", low, HIT_LOW);
        end
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++; $display("FAIL hit_count: got %0d want %0d", wq.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++; $display("FAIL hit_w%0d: got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_row_wrap();
        int low;
        wq = {}; exp_q = {};
        build_full(8'd239, 9'd5, 16'h1234);
        build_pred(8'd0, 9'd6, 16'hABCD);
        send(8'd239, 9'd5, 16'h1234, low);
        send(8'd0, 9'd6, 16'hABCD, low);
        checks++;
        if (low != HIT_LOW) begin
            errors++; $display("FAIL wrap_low: got %0d want %0d", low, HIT_LOW);
        end
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++; $display("FAIL wrap_count: got %0d want %0d", wq.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap_w%0d: got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_non_sequential();
        int low;
        wq = {}; exp_q = {};
        build_full(8'd3, 9'd5, 16'h0101);
        build_full(8'd5, 9'd5, 16'h0202);
        send(8'd3, 9'd5, 16'h0101, low);
        send(8'd5, 9'd5, 16'h0202, low);
        checks++;
        if (low != MISS_LOW) begin
            errors++; $display("FAIL nonseq_low: got %0d want %0d", low, MISS_LOW);
        end
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++; $display("FAIL nonseq_count: got %0d want %0d", wq.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++; $display("FAIL nonseq_w%0d: got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_drop();
        int low;
        wq = {}; exp_q = {};
        send(8'd240, 9'd0, 16'hDEAD, low);
        checks++;
        if (low != 1 || wq.size() != 0) begin
            errors++; $display("FAIL drop_x: got low=%0d writes=%0d want 1 0", low, wq.size());
        end
        send(8'd0, 9'd320, 16'hBEEF, low);
        checks++;
        if (low != 1 || wq.size() != 0) begin
            errors++; $display("FAIL drop_y: got low=%0d writes=%0d want 1 0", low, wq.size());
        end
        build_full(8'd0, 9'd0, 16'h5555);
        send(8'd0, 9'd0, 16'h5555, low);
        checks++;
        if (low != MISS_LOW) begin
            errors++; $display("FAIL after_drop_low: got %0d want %0d", low, MISS_LOW);
        end
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++; $display("FAIL after_drop_count: got %0d want %0d", wq.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++; $display("FAIL after_drop_w%0d: got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int low;
        wq = {}; exp_q = {};
        xAddr = 8'd10; yAddr = 9'd20; pixelData = 16'h7777; pixelWrite = 1'b1;
        @(posedge clock);
        #1 pixelWrite = 1'b0;
        while (wq.size() < 7 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (wq.size() != 7) begin
            errors++; $display("FAIL mid_progress: got %0d writes want 7", wq.size());
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({LT24CS_n, LT24Wr_n, LT24Data} !== {2'b11, 16'h0}) begin
            errors++;
            $display("FAIL mid_reset_bus: got cs=%b wr=%b data=%h want 1 1 0000",
                     LT24CS_n, LT24Wr_n, LT24Data);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        wq = {};
        build_full(8'd1, 9'd0, 16'h3C3C);
        send(8'd1, 9'd0, 16'h3C3C, low);
        checks++;
        if (low != MISS_LOW || wq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL post_reset: got low=%0d writes=%0d want %0d %0d",
                     low, wq.size(), MISS_LOW, exp_q.size());
        end
    endtask

    task automatic test_init_falling();
        int n = 0;
        int rdy_hi = 0;
        wq = {}; exp_q = {};
        build_full(8'd50, 9'd50, 16'h9999);
        xAddr = 8'd50; yAddr = 9'd50; pixelData = 16'h9999; pixelWrite = 1'b1;
        @(posedge clock);
        #1 pixelWrite = 1'b0;
        initDone = 1'b0;
        while (n < 40) begin
            @(negedge clock);
            if (pixelReady !== 1'b0) rdy_hi++;
            n++;
        end
        checks++;
        if (rdy_hi != 0) begin
            errors++; $display("FAIL init_low_ready: got %0d ready cycles want 0", rdy_hi);
        end
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++; $display("FAIL init_low_count: got %0d want %0d", wq.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++; $display("FAIL init_low_w%0d: got %h want %h", i, wq[i], exp_q[i]);
            end
        end
        wq = {};
        pixelWrite = 1'b1;
        repeat (5) @(negedge clock);
        pixelWrite = 1'b0;
        @(negedge clock);
        checks++;
        if (wq.size() != 0 || pixelReady !== 1'b0) begin
            errors++;
            $display("FAIL init_gate: got writes=%0d rdy=%b want 0 0", wq.size(), pixelReady);
        end
        initDone = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_row_wrap();
        test_non_sequential();
        test_drop();
        test_reset_mid();
        test_init_falling();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lt24_pixel_writer.md
# lt24_pixel_writer

Pixel-side responder for the LT24 panel: accepts `xAddr`/`yAddr`/`pixelData` writes over the `pixelWrite`/`pixelReady` handshake that the game display logic drives, and turns each pixel into 8080-style 16-bit bus writes to the ILI9341 (column set, page set, RAM write, pixel data). It tracks the panel's auto-incrementing write pointer and skips address commands when the incoming pixel is the next in raster order. Panel power-up and initialisation are outside this block; `initDone` gates acceptance.

## Interface
- `LCD_WIDTH`, 240, columns; column window end = LCD_WIDTH-1
- `LCD_HEIGHT`, 320, rows; page window end = LCD_HEIGHT-1
- `WR_LOW_CYCLES`, 1, cycles `LT24Wr_n` is held low per bus write (≥1)
- `WR_HIGH_CYCLES`, 1, cycles `LT24Wr_n` is held high after each low phase (≥1)

- `clock` in 1 — single clock; all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `initDone` in 1 — panel initialised; new pixels are accepted only while high
- `xAddr` in 8 — pixel column
- `yAddr` in 9 — pixel row
- `pixelData` in 16 — RGB565 colour
- `pixelWrite` in 1 — request; transfer when `pixelWrite && pixelReady` at a rising edge
- `pixelReady` out 1 — block can accept a pixel this cycle
- `LT24Wr_n` out 1 — write strobe, panel latches on rising edge
- `LT24Rd_n` out 1 — constant 1
- `LT24CS_n` out 1 — chip select, active low
- `LT24RS` out 1 — 0 command, 1 parameter/data
- `LT24Data` out 16 — bus data

## Operation
- States: IDLE, ADDR (write index 0..10), DATA, DROP.
- IDLE: `pixelReady = initDone`; `LT24CS_n=1`. On transfer, latch x, y, data.
- Out of range (x ≥ LCD_WIDTH or y ≥ LCD_HEIGHT): go to DROP for 1 cycle, no bus activity, clear the prediction-valid flag, return to IDLE.
- Predicted next address: (px+1, py); at px = LCD_WIDTH-1 → (0, py+1); at (LCD_WIDTH-1, LCD_HEIGHT-1) → (0,0). Valid flag set after each completed DATA write.
- Hit (valid and x,y == predicted): go straight to DATA (1 bus write).
- Miss: ADDR sequence, then DATA; 12 writes total, in this order: RS=0 0x002A; RS=1 x[15:8], x[7:0], (W-1)[15:8], (W-1)[7:0]; RS=0 0x002B; RS=1 y[15:8], y[7:0], (H-1)[15:8], (H-1)[7:0]; RS=0 0x002C; RS=1 pixel data. Parameter bytes sit on `LT24Data[7:0]` with `[15:8]=0`.
- Each bus write: `LT24Data`/`LT24RS` stable for the whole write; `LT24Wr_n` low for WR_LOW_CYCLES, then high for WR_HIGH_CYCLES.
- `LT24CS_n` is low in every non-IDLE, non-DROP cycle.
- `initDone` falling mid-sequence: current pixel completes; no new accept.
- `reset` mid-sequence: in-flight pixel discarded; all outputs at reset values the next cycle; prediction flag cleared.

## Timing
- Reset values: `pixelReady=0`, `LT24Wr_n=1`, `LT24Rd_n=1`, `LT24CS_n=1`, `LT24RS=1`, `LT24Data=0`; state IDLE, prediction invalid.
- Accept at edge E0; first write's low phase begins in the cycle after E0.
- `pixelReady` drops the cycle after accept and rises in the final high-phase cycle of the last write, so back-to-back transfers need no idle cycle.
- With N writes and P = WR_LOW_CYCLES+WR_HIGH_CYCLES: `pixelReady` is low for N·P−1 cycles. Defaults: hit 1 cycle (2 cycles/pixel), miss 23 cycles. DROP: low 1 cycle.

## Configuration
- `LT24_PIXEL_WRITER_SKIP_ADDR_EN` defined: hit/miss prediction as above.
- Undefined: the prediction logic is removed; every in-range pixel takes the full 12-write sequence.

## Test plan
- Reset, `initDone=1`, write (0,0,0xF800) → 12 writes: 0x2A,0,0,0x00,0xEF,0x2B,0,0,0x01,0x3F,0x2C (RS 0/1 as specified), then RS=1 0xF800; `pixelReady` low 23 cycles.
- Then (1,0,0x07E0) → a single RS=1 write of 0x07E0; `pixelReady` low 1 cycle.
- Hit across the row wrap: (239,5) then (0,6) → data-only write. Non-sequential: (3,5) then (5,5) → full sequence with column params 0x00,0x05.
- (240,0) → no `LT24Wr_n` low, `pixelReady` low 1 cycle. A following (0,0) takes the full sequence.
- Assert `reset` during the 0x2B parameter writes → next cycle `LT24CS_n=1`, `LT24Wr_n=1`, `LT24Data=0`. The next pixel takes the full sequence.
- Build without the macro: (0,0) then (1,0) → 12 writes each; `initDone=0` → `pixelReady=0`, no transfers.
